// File: rtl/temp_sched_pkg.sv
// ============================================================================
//  Module      : temp_sched_pkg
//  Description : Shared FSM state encoding, default parameters and the
//                index-width helper for the temperature zone scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package temp_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam int DEF_NZONES  = 4;
  localparam int DEF_HYST    = 2;
  localparam int DEF_DWELL   = 3;
  localparam int DEF_TIMEOUT = 16;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int zone_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/temp_zone_decide.sv
// ============================================================================
//  Module      : temp_zone_decide
//  Description : Heat/cool demand comparator plus dwell hold, time-shared
//                across all zones. TEMP_SCHED_HYST_EN selects the HYST band.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_zone_decide
  import temp_sched_pkg::*;
#(
  parameter int HYST  = DEF_HYST,
  parameter int DWELL = DEF_DWELL,
  parameter int DW    = zone_w(DEF_DWELL + 1)
) (
  input  logic [7:0]    i_temp,
  input  logic [7:0]    i_sp,
  input  logic          i_cur_heat,
  input  logic          i_cur_cold,
  input  logic [DW-1:0] i_dwell,
  output logic          o_heat,
  output logic          o_cold,
  output logic [DW-1:0] o_dwell
);

  logic [8:0] w_temp9;
  logic [8:0] w_sp9;
  logic       w_dem_heat;
  logic       w_dem_cold;

  assign w_temp9 = {1'b0, i_temp};
  assign w_sp9   = {1'b0, i_sp};

`ifdef TEMP_SCHED_HYST_EN
  assign w_dem_heat = (w_temp9 + 9'(HYST)) < w_sp9;
  assign w_dem_cold = w_temp9 > (w_sp9 + 9'(HYST));
`else
  logic [8:0] w_unused_hyst;
  assign w_unused_hyst = 9'(HYST);
  assign w_dem_heat    = w_temp9 < w_sp9;
  assign w_dem_cold    = w_temp9 > w_sp9;
`endif

  // A running dwell counter freezes the outputs; only an idle counter may change them.
  always_comb begin
    o_heat  = i_cur_heat;
    o_cold  = i_cur_cold;
    o_dwell = i_dwell;
    if (i_dwell != '0) begin
      o_dwell = i_dwell - DW'(1);
    end else if ({w_dem_heat, w_dem_cold} != {i_cur_heat, i_cur_cold}) begin
      o_heat  = w_dem_heat;
      o_cold  = w_dem_cold;
      o_dwell = DW'(DWELL);
    end
  end

endmodule

`default_nettype wire

// File: rtl/temp_zone_scheduler.sv
// ============================================================================
//  Module      : temp_zone_scheduler
//  Description : Round-robin multi-zone thermostat over one shared sensor bus
//                with read timeout, dwell hold and optional hysteresis
//                (macro TEMP_SCHED_HYST_EN).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_zone_scheduler
  import temp_sched_pkg::*;
#(
  parameter int NZONES  = DEF_NZONES,
  parameter int HYST    = DEF_HYST,
  parameter int DWELL   = DEF_DWELL,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NZONES*8-1:0]         set_point,
  input  logic [7:0]                  temperature,
  input  logic                        sensor_valid,
  output logic                        sensor_req,
  output logic [zone_w(NZONES)-1:0]   sensor_sel,
  output logic [NZONES-1:0]           heat,
  output logic [NZONES-1:0]           cold,
  output logic [NZONES-1:0]           fault,
  output logic                        scan_done
);

  localparam int ZW = zone_w(NZONES);
  localparam int DW = zone_w(DWELL + 1);
  localparam int TW = zone_w(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ZW-1:0]     r_zone;
  logic [TW-1:0]     r_tcnt;
  logic [7:0]        r_temp;
  logic [NZONES-1:0] r_heat;
  logic [NZONES-1:0] r_cold;
  logic [NZONES-1:0] r_fault;
  logic [DW-1:0]     r_dwell [NZONES];
  logic              r_scan_done;

  logic              w_valid_hit;
  logic              w_timeout;
  logic              w_zone_done;
  logic              w_last;
  logic [7:0]        w_sp;
  logic              w_new_heat;
  logic              w_new_cold;
  logic [DW-1:0]     w_new_dwell;

  assign w_valid_hit = (r_state == S_WAIT) && sensor_valid;
  // A valid read on the final WAIT cycle takes priority over the timeout.
  assign w_timeout   = (r_state == S_WAIT) && !sensor_valid && (r_tcnt == TW'(TIMEOUT - 1));
  assign w_zone_done = (r_state == S_EVAL) || w_timeout;
  assign w_last      = (r_zone == ZW'(NZONES - 1));
  assign w_sp        = set_point[{r_zone, 3'b000} +: 8];

  temp_zone_decide #(
    .HYST  (HYST),
    .DWELL (DWELL),
    .DW    (DW)
  ) u_decide (
    .i_temp     (r_temp),
    .i_sp       (w_sp),
    .i_cur_heat (r_heat[r_zone]),
    .i_cur_cold (r_cold[r_zone]),
    .i_dwell    (r_dwell[r_zone]),
    .o_heat     (w_new_heat),
    .o_cold     (w_new_cold),
    .o_dwell    (w_new_dwell)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    sensor_req  = 1'b0;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_WAIT;
      S_WAIT: begin
        sensor_req = 1'b1;
        if (sensor_valid)   w_state_nxt = S_EVAL;
        else if (w_timeout) w_state_nxt = enable ? S_WAIT : S_IDLE;
      end
      S_EVAL:  w_state_nxt = enable ? S_WAIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zone      <= '0;
      r_tcnt      <= '0;
      r_temp      <= '0;
      r_heat      <= '0;
      r_cold      <= '0;
      r_fault     <= '0;
      r_scan_done <= 1'b0;
      for (int i = 0; i < NZONES; i++) r_dwell[i] <= '0;
    end else begin
      r_scan_done <= w_zone_done && w_last;
      if ((r_state == S_WAIT) && !sensor_valid && !w_timeout) r_tcnt <= r_tcnt + TW'(1);
      else                                                    r_tcnt <= '0;
      if (w_valid_hit) r_temp <= temperature;
      if (r_state == S_EVAL) begin
        r_heat[r_zone]  <= w_new_heat;
        r_cold[r_zone]  <= w_new_cold;
        r_dwell[r_zone] <= w_new_dwell;
        r_fault[r_zone] <= 1'b0;
      end else if (w_timeout) begin
        r_heat[r_zone]  <= 1'b0;
        r_cold[r_zone]  <= 1'b0;
        r_dwell[r_zone] <= '0;
        r_fault[r_zone] <= 1'b1;
      end
      if (w_zone_done) r_zone <= w_last ? '0 : r_zone + ZW'(1);
    end
  end

  assign sensor_sel = r_zone;
  assign heat       = r_heat;
  assign cold       = r_cold;
  assign fault      = r_fault;
  assign scan_done  = r_scan_done;

endmodule

`default_nettype wire

// File: tb/tb_temp_zone_scheduler.sv
// ============================================================================
//  Module      : tb_temp_zone_scheduler
//  Description : Directed self-checking bench for temp_zone_scheduler
//                (NZONES=4, HYST=2, DWELL=3, TIMEOUT=16).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_temp_zone_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] set_point;
  logic [7:0]  temperature;
  logic        sensor_valid;
  logic        sensor_req;
  logic [1:0]  sensor_sel;
  logic [3:0]  heat;
  logic [3:0]  cold;
  logic [3:0]  fault;
  logic        scan_done;

  int n_vec = 0;
  int n_err = 0;
  logic exp_c1;

  temp_zone_scheduler #(
    .NZONES  (4),
    .HYST    (2),
    .DWELL   (3),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .set_point    (set_point),
    .temperature  (temperature),
    .sensor_valid (sensor_valid),
    .sensor_req   (sensor_req),
    .sensor_sel   (sensor_sel),
    .heat         (heat),
    .cold         (cold),
    .fault        (fault),
    .scan_done    (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Answer the pending request with temperature t, then leave EVAL.
  task automatic serve(input logic [7:0] t);
    check_val("req_before_read", {31'b0, sensor_req}, 32'd1);
    sensor_valid = 1'b1;
    temperature  = t;
    tick();
    sensor_valid = 1'b0;
    tick();
  endtask

  initial begin
`ifdef TEMP_SCHED_HYST_EN
    exp_c1 = 1'b0;
`else
    exp_c1 = 1'b1;
`endif
    reset        = 1'b1;
    enable       = 1'b1;
    set_point    = {8'd20, 8'd20, 8'd20, 8'd20};
    temperature  = 8'd0;
    sensor_valid = 1'b0;

    repeat (3) tick();
    check_val("rst_heat", {28'b0, heat}, 32'h0);
    check_val("rst_cold", {28'b0, cold}, 32'h0);
    check_val("rst_fault", {28'b0, fault}, 32'h0);
    check_val("rst_req", {31'b0, sensor_req}, 32'h0);
    check_val("rst_sel", {30'b0, sensor_sel}, 32'h0);
    check_val("rst_done", {31'b0, scan_done}, 32'h0);

    reset = 1'b0;
    tick();
    check_val("first_req", {31'b0, sensor_req}, 32'd1);
    check_val("first_sel", {30'b0, sensor_sel}, 32'd0);

    // Pass 1: zone 0 heat, zone 1 near set point, zone 2 times out, zone 3 on target.
    sensor_valid = 1'b1;
    temperature  = 8'd12;
    tick();
    sensor_valid = 1'b0;
    check_val("z0_heat_at_capture", {28'b0, heat}, 32'h0);
    tick();
    check_val("z0_heat", {31'b0, heat[0]}, 32'd1);
    check_val("z0_cold", {31'b0, cold[0]}, 32'd0);
    check_val("sel_after_z0", {30'b0, sensor_sel}, 32'd1);

    serve(8'd21);
    check_val("z1_cold_t21", {31'b0, cold[1]}, {31'b0, exp_c1});
    check_val("z1_heat_t21", {31'b0, heat[1]}, 32'd0);
    check_val("done_mid_pass", {31'b0, scan_done}, 32'd0);

    repeat (15) tick();
    check_val("z2_fault_15cyc", {28'b0, fault}, 32'h0);
    check_val("z2_sel_15cyc", {30'b0, sensor_sel}, 32'd2);
    tick();
    check_val("z2_fault_16cyc", {28'b0, fault}, 32'h4);
    check_val("z2_hc_timeout", {30'b0, heat[2], cold[2]}, 32'd0);
    check_val("z2_sel_timeout", {30'b0, sensor_sel}, 32'd3);

    serve(8'd20);
    check_val("z3_off", {30'b0, heat[3], cold[3]}, 32'd0);
    check_val("scan_done_pulse", {31'b0, scan_done}, 32'd1);
    check_val("sel_wrap", {30'b0, sensor_sel}, 32'd0);
    tick();
    check_val("scan_done_one_cycle", {31'b0, scan_done}, 32'd0);

    // Pass 2: zone 0 hot but dwell holds heat; zone 2 recovers from fault.
    serve(8'd30);
    check_val("z0_dwell1_heat", {31'b0, heat[0]}, 32'd1);
    check_val("z0_dwell1_cold", {31'b0, cold[0]}, 32'd0);
    serve(8'd23);
    check_val("z1_cold_t23", {31'b0, cold[1]}, 32'd1);
    serve(8'd12);
    check_val("z2_fault_cleared", {28'b0, fault}, 32'h0);
    check_val("z2_heat", {31'b0, heat[2]}, 32'd1);
    serve(8'd20);

    // Passes 3-4: dwell still holding zone 0.
    serve(8'd30);
    check_val("z0_dwell2_heat", {31'b0, heat[0]}, 32'd1);
    serve(8'd23);
    serve(8'd12);
    serve(8'd20);
    serve(8'd30);
    check_val("z0_dwell3_heat", {31'b0, heat[0]}, 32'd1);
    serve(8'd23);
    serve(8'd12);
    serve(8'd20);

    // Pass 5: dwell expired, zone 0 switches to cooling.
    serve(8'd30);
    check_val("z0_switch_cold", {31'b0, cold[0]}, 32'd1);
    check_val("z0_switch_heat", {31'b0, heat[0]}, 32'd0);
    check_val("no_heat_and_cold", {28'b0, heat & cold}, 32'h0);

    // Enable drops during WAIT: zone 1 completes, then IDLE.
    enable = 1'b0;
    tick();
    check_val("wait_holds_req", {31'b0, sensor_req}, 32'd1);
    serve(8'd21);
    check_val("idle_req", {31'b0, sensor_req}, 32'd0);
    check_val("idle_sel", {30'b0, sensor_sel}, 32'd2);
    sensor_valid = 1'b1;
    temperature  = 8'd0;
    tick();
    sensor_valid = 1'b0;
    tick();
    check_val("idle_ignores_valid", {31'b0, sensor_req}, 32'd0);
    check_val("idle_heat", {28'b0, heat}, 32'h4);
    check_val("idle_cold", {28'b0, cold}, 32'h3);
    check_val("idle_fault", {28'b0, fault}, 32'h0);

    // Reset during EVAL abandons the read; restart at zone 0.
    enable = 1'b1;
    tick();
    check_val("resume_sel", {30'b0, sensor_sel}, 32'd2);
    sensor_valid = 1'b1;
    temperature  = 8'd30;
    tick();
    sensor_valid = 1'b0;
    reset        = 1'b1;
    tick();
    check_val("mid_rst_heat", {28'b0, heat}, 32'h0);
    check_val("mid_rst_cold", {28'b0, cold}, 32'h0);
    check_val("mid_rst_sel", {30'b0, sensor_sel}, 32'd0);
    check_val("mid_rst_req", {31'b0, sensor_req}, 32'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_req", {31'b0, sensor_req}, 32'd1);
    check_val("post_rst_sel", {30'b0, sensor_sel}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/temp_zone_scheduler.md
TEMP_ZONE_SCHEDULER -- requirements
Module: temp_zone_scheduler

Interface
REQ-001 SHALL have parameter NZONES, default 4, number of zones scanned round-robin over one shared sensor bus.
REQ-002 SHALL have parameter HYST, default 2, hysteresis band in temperature units.
REQ-003 SHALL have parameter DWELL, default 3, zone evaluations an output is held after it changes.
REQ-004 SHALL have parameter TIMEOUT, default 16, WAIT cycles allowed before a sensor read is declared failed.
REQ-005 SHALL have port clk  input  1  single clock, rising edge; reset is synchronous and active-high.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port enable  input  1  scan enable.
REQ-008 SHALL have port set_point  input  NZONES*8  packed unsigned set points, zone z at bits [8z+7:8z].
REQ-009 SHALL have port temperature  input  8  unsigned reading for the selected zone.
REQ-010 SHALL have port sensor_valid  input  1  temperature valid this cycle.
REQ-011 SHALL have port sensor_req  output  1  reading requested for the zone on sensor_sel.
REQ-012 SHALL have port sensor_sel  output  clog2(NZONES)  zone currently requested.
REQ-013 SHALL have ports heat, cold, fault  output  NZONES each  per-zone heat demand, cool demand and read-failure flag.
REQ-014 SHALL have port scan_done  output  1  one-cycle pulse at the end of each full pass.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and EVAL, with a zone index that wraps from NZONES-1 to 0.
REQ-016 IDLE: sensor_req=0; when enable=1, SHALL go to WAIT.
REQ-017 WAIT: SHALL drive sensor_req=1 and sensor_sel=zone index, and count cycles spent in WAIT.
REQ-018 WAIT: on the edge sampling sensor_valid=1, SHALL capture temperature and go to EVAL; sensor_valid SHALL be ignored outside WAIT.
REQ-019 WAIT timeout: on the TIMEOUT-th consecutive WAIT cycle without sensor_valid, SHALL clear that zone's heat/cold and dwell counter, set its fault bit, and advance the zone; if sensor_valid arrives on that same cycle, the valid read wins.
REQ-020 EVAL (one cycle): SHALL read the zone's set_point in this cycle, update heat/cold on the edge leaving EVAL (one edge after capture), clear that zone's fault bit, and advance the zone.
REQ-021 Decision: heat demand SHALL be temp+HYST < sp and cold demand SHALL be temp > sp+HYST, both computed 9 bits wide with no overflow; a zone with neither demand SHALL request off.
REQ-022 Dwell: a zone with a nonzero dwell counter at EVAL SHALL decrement it and hold its outputs; when the counter is zero and the demand differs from the current outputs, outputs SHALL update and the counter SHALL load DWELL.
REQ-023 heat[z] and cold[z] SHALL never both be 1.
REQ-024 scan_done SHALL pulse for one cycle when the zone index wraps from NZONES-1 to 0, whether the last zone ended by EVAL or by timeout.
REQ-025 After EVAL or timeout, SHALL go to WAIT if enable=1, otherwise to IDLE; enable dropping during WAIT SHALL let the current zone finish.
REQ-026 Zones not currently being evaluated SHALL keep their heat/cold/fault values unchanged.

Reset
REQ-027 While reset=1, at each rising edge, SHALL set state IDLE, zone index 0, and clear heat, cold, fault, scan_done, sensor_req, sensor_sel, all dwell counters, the timeout counter and the captured temperature.
REQ-028 Reset asserted mid-WAIT or mid-EVAL SHALL abandon the read with no output update; the first request after reset SHALL be for zone 0.

Configuration
REQ-029 Macro TEMP_SCHED_HYST_EN defined: decision SHALL use the HYST band per REQ-021.
REQ-030 Macro TEMP_SCHED_HYST_EN undefined: SHALL use heat = temp < sp and cold = temp > sp, with HYST unused; all other behaviour SHALL be identical.

Structure
REQ-031 Package temp_sched_pkg SHALL hold the FSM state enum, the default parameter constants and the zone-index width function.
REQ-032 Sub-module temp_zone_decide SHALL hold the shared comparator plus dwell logic, instantiated once and time-shared across zones.

Verification (NZONES=4, HYST=2, DWELL=3, TIMEOUT=16)
REQ-033 Reset held 3 cycles with enable=1 -> all outputs 0; first post-reset cycle has sensor_req=1 and sensor_sel=0.
REQ-034 Zone 0 with sp=20, temp=12 valid -> heat[0]=1 one edge after capture; cold[0]=0; sensor_sel advances to 1.
REQ-035 sp=20 with temp=21 then temp=23, macro on -> no change, then cold=1; macro off, temp=21 -> cold=1.
REQ-036 Zone 0 heat just set, next visits temp=30 -> heat held for 3 evaluations, then cold[0]=1 at the 4th.
REQ-037 Zone 2 with no sensor_valid for 16 cycles -> heat[2]=cold[2]=0, fault[2]=1, sensor_sel=3; the next valid read of zone 2 clears fault[2].
REQ-038 Four consecutive valid reads -> one scan_done pulse after zone 3 EVAL; enable=0 during WAIT -> the zone completes, then IDLE with sensor_req=0.
